// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing signal bundle between generator and pixel stage
`timescale 1ns/1ps
interface vga_timing_gen_if;
    logic       PIX_CE;
    logic [9:0] HC;
    logic [9:0] VC;
    logic       VIDON;
    logic       HSYNC;
    logic       VSYNC;
    logic       LINE_START;
    logic       FRAME_START;

    modport master (
        output PIX_CE, HC, VC, VIDON, HSYNC, VSYNC, LINE_START, FRAME_START
    );

    modport slave (
        input PIX_CE, HC, VC, VIDON, HSYNC, VSYNC, LINE_START, FRAME_START
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (pixel divider, H/V counters, registered decodes)
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic              CLK,
    input  logic              RST_N,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds held one bit wider so a sync window ending at 1024 still compares correctly
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [4:0]  r_div;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic        r_vidon;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_line_start;
    logic        r_frame_start;

    logic        w_tick;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [9:0]  w_hc_next;
    logic [9:0]  w_vc_next;
    logic [10:0] w_hc_ext;
    logic [10:0] w_vc_ext;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_h_wrap  = (r_hc == H_LAST);
    assign w_v_wrap  = (r_vc == V_LAST);
    assign w_hc_next = w_h_wrap ? 10'd0 : r_hc + 10'd1;
    assign w_vc_next = w_h_wrap ? (w_v_wrap ? 10'd0 : r_vc + 10'd1) : r_vc;
    assign w_hc_ext  = {1'b0, w_hc_next};
    assign w_vc_ext  = {1'b0, w_vc_next};

    // Pixel-rate divider: counts system clocks within one pixel period
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_div <= 5'd0;
        end else if (w_tick) begin
            r_div <= 5'd0;
        end else begin
            r_div <= r_div + 5'd1;
        end
    end

    // Counters and decodes advance together on a tick; decodes come from the next-state counts
    // so they line up with HC/VC in the same cycle. Reset parks on the last pixel of a frame.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_hc          <= H_LAST;
            r_vc          <= V_LAST;
            r_vidon       <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_vidon       <= (w_hc_ext < H_VIS) && (w_vc_ext < V_VIS);
            r_hsync       <= !((w_hc_ext >= HS_BEG) && (w_hc_ext < HS_END));
            r_vsync       <= !((w_vc_ext >= VS_BEG) && (w_vc_ext < VS_END));
            r_line_start  <= (w_hc_next == 10'd0);
            r_frame_start <= (w_hc_next == 10'd0) && (w_vc_next == 10'd0);
        end
    end

    assign vga.PIX_CE      = w_tick;
    assign vga.HC          = r_hc;
    assign vga.VC          = r_vc;
    assign vga.VIDON       = r_vidon;
    assign vga.HSYNC       = r_hsync;
    assign vga.VSYNC       = r_vsync;
    assign vga.LINE_START  = r_line_start;
    assign vga.FRAME_START = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen at three raster configurations
`timescale 1ns/1ps
module tb_vga_timing_gen;
    typedef struct packed { int cd, ha, hfp, hs, hbp, va, vfp, vs, vbp; } prm_t;
    typedef struct packed { int div, hc, vc; } st_t;
    typedef struct packed {
        logic       pix_ce;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       vidon, hsync, vsync, ls, fs;
    } exp_t;

    localparam prm_t P_DEF = '{cd:2, ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33};
    localparam prm_t P_SML = '{cd:1, ha:8,   hfp:1,  hs:2,  hbp:1,  va:4,   vfp:1,  vs:1, vbp:1};
    localparam prm_t P_MID = '{cd:3, ha:20,  hfp:3,  hs:5,  hbp:4,  va:12,  vfp:2,  vs:3, vbp:2};

    logic clk = 1'b0;
    logic rst_def = 1'b0;
    logic rst_sml = 1'b0;
    logic rst_mid = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if if_def();
    vga_timing_gen_if if_sml();
    vga_timing_gen_if if_mid();

    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                     .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33))
        u_def (.CLK(clk), .RST_N(rst_def), .vga(if_def));
    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1))
        u_sml (.CLK(clk), .RST_N(rst_sml), .vga(if_sml));
    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
                     .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2))
        u_mid (.CLK(clk), .RST_N(rst_mid), .vga(if_mid));

    int total = 0;
    int bad   = 0;
    st_t  st_def, st_sml, st_mid;
    exp_t q_def[$];
    exp_t q_sml[$];
    exp_t q_mid[$];

    function automatic st_t m_step(st_t s, logic rst_n, prm_t p);
        st_t n;
        int ht = p.ha + p.hfp + p.hs + p.hbp;
        int vt = p.va + p.vfp + p.vs + p.vbp;
        n = s;
        if (!rst_n) begin
            n.div = 0; n.hc = ht - 1; n.vc = vt - 1;
        end else if (s.div == p.cd - 1) begin
            n.div = 0;
            if (s.hc == ht - 1) begin
                n.hc = 0;
                n.vc = (s.vc == vt - 1) ? 0 : s.vc + 1;
            end else begin
                n.hc = s.hc + 1;
            end
        end else begin
            n.div = s.div + 1;
        end
        return n;
    endfunction

    function automatic exp_t m_out(st_t s, prm_t p);
        exp_t e;
        e.pix_ce = (s.div == p.cd - 1);
        e.hc     = 10'(s.hc);
        e.vc     = 10'(s.vc);
        e.vidon  = (s.hc < p.ha) && (s.vc < p.va);
        e.hsync  = !((s.hc >= p.ha + p.hfp) && (s.hc < p.ha + p.hfp + p.hs));
        e.vsync  = !((s.vc >= p.va + p.vfp) && (s.vc < p.va + p.vfp + p.vs));
        e.ls     = (s.hc == 0);
        e.fs     = (s.hc == 0) && (s.vc == 0);
        return e;
    endfunction

    task automatic cyc_def(input logic r, output exp_t e, output exp_t o);
        @(negedge clk);
        rst_def = r;
        st_def = m_step(st_def, r, P_DEF);
        q_def.push_back(m_out(st_def, P_DEF));
        @(posedge clk); #1;
        o = {if_def.PIX_CE, if_def.HC, if_def.VC, if_def.VIDON, if_def.HSYNC, if_def.VSYNC,
             if_def.LINE_START, if_def.FRAME_START};
        e = q_def.pop_front();
    endtask

    task automatic cyc_sml(input logic r, output exp_t e, output exp_t o);
        @(negedge clk);
        rst_sml = r;
        st_sml = m_step(st_sml, r, P_SML);
        q_sml.push_back(m_out(st_sml, P_SML));
        @(posedge clk); #1;
        o = {if_sml.PIX_CE, if_sml.HC, if_sml.VC, if_sml.VIDON, if_sml.HSYNC, if_sml.VSYNC,
             if_sml.LINE_START, if_sml.FRAME_START};
        e = q_sml.pop_front();
    endtask

    task automatic cyc_mid(input logic r, output exp_t e, output exp_t o);
        @(negedge clk);
        rst_mid = r;
        st_mid = m_step(st_mid, r, P_MID);
        q_mid.push_back(m_out(st_mid, P_MID));
        @(posedge clk); #1;
        o = {if_mid.PIX_CE, if_mid.HC, if_mid.VC, if_mid.VIDON, if_mid.HSYNC, if_mid.VSYNC,
             if_mid.LINE_START, if_mid.FRAME_START};
        e = q_mid.pop_front();
    endtask

    task automatic test_reset();
        exp_t e, o;
        logic want_ce;
        for (int i = 0; i < 3; i++) begin
            cyc_def(1'b0, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_hold got=%h want=%h", o, e); end
        end
        total++;
        if (o.hc !== 10'd799 || o.vc !== 10'd524 || o.vidon !== 1'b0 || o.hsync !== 1'b1 ||
            o.vsync !== 1'b1 || o.pix_ce !== 1'b0 || o.ls !== 1'b0 || o.fs !== 1'b0) begin
            bad++; $display("FAIL reset_values got hc=%0d vc=%0d flags=%h want hc=799 vc=524", o.hc, o.vc, o);
        end
        cyc_def(1'b1, e, o);
        total++;
        if (o !== e) begin bad++; $display("FAIL release_edge1 got=%h want=%h", o, e); end
        cyc_def(1'b1, e, o);
        total++;
        if (o !== e) begin bad++; $display("FAIL release_edge2 got=%h want=%h", o, e); end
        total++;
        if (o.hc !== 10'd0 || o.vc !== 10'd0 || o.vidon !== 1'b1 || o.ls !== 1'b1 || o.fs !== 1'b1) begin
            bad++; $display("FAIL first_tick got hc=%0d vc=%0d vidon=%b fs=%b want hc=0 vc=0 vidon=1 fs=1",
                            o.hc, o.vc, o.vidon, o.fs);
        end
        for (int i = 1; i <= 20; i++) begin
            cyc_def(1'b1, e, o);
            want_ce = (i % 2) == 1;
            total++;
            if (o.pix_ce !== want_ce) begin bad++; $display("FAIL pix_ce_rate i=%0d got=%b want=%b", i, o.pix_ce, want_ce); end
            total++;
            if (o !== e) begin bad++; $display("FAIL pix_ce_scan got=%h want=%h", o, e); end
        end
    endtask

    task automatic test_line_scan();
        exp_t e, o, prev;
        int hs_clocks = 0;
        int wraps = 0;
        int ls_run = 0;
        cyc_def(1'b0, e, prev);
        for (int i = 0; i < 3300; i++) begin
            cyc_def(1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL line_scan cyc=%0d got=%h want=%h", i, o, e); end
            if (prev.vidon && !o.vidon) begin
                total++;
                if (prev.hc !== 10'd639 || o.hc !== 10'd640) begin
                    bad++; $display("FAIL vidon_fall got %0d->%0d want 639->640", prev.hc, o.hc);
                end
            end
            if (o.vc == 10'd0 && !o.hsync) hs_clocks++;
            if (prev.hsync && !o.hsync) begin
                total++;
                if (o.hc !== 10'd656) begin bad++; $display("FAIL hsync_fall got hc=%0d want 656", o.hc); end
            end
            if (!prev.hsync && o.hsync) begin
                total++;
                if (o.hc !== 10'd752) begin bad++; $display("FAIL hsync_rise got hc=%0d want 752", o.hc); end
            end
            if (prev.hc == 10'd799 && o.hc == 10'd0) begin
                wraps++;
                if (wraps == 2) begin
                    total++;
                    if (prev.vc !== 10'd0 || o.vc !== 10'd1) begin
                        bad++; $display("FAIL hc_vc_wrap got vc %0d->%0d want 0->1", prev.vc, o.vc);
                    end
                end
            end
            if (o.ls) begin
                ls_run++;
            end else if (ls_run != 0) begin
                total++;
                if (ls_run != 2) begin bad++; $display("FAIL line_start_width got=%0d want=2", ls_run); end
                ls_run = 0;
            end
            prev = o;
        end
        total++;
        if (hs_clocks != 192) begin bad++; $display("FAIL hsync_width got=%0d want=192", hs_clocks); end
        total++;
        if (wraps != 3) begin bad++; $display("FAIL line_wraps got=%0d want=3", wraps); end
    endtask

    task automatic test_mid_reset();
        exp_t e, o;
        logic found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cyc_def(1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL pre_reset_def got=%h want=%h", o, e); end
            if (o.hc == 10'd700) found = 1'b1;
        end
        total++;
        if (!found || o.hsync !== 1'b0) begin bad++; $display("FAIL reach_hc700 got found=%b hsync=%b want 1 0", found, o.hsync); end
        cyc_def(1'b0, e, o);
        total++;
        if (o.hsync !== 1'b1 || o.vsync !== 1'b1 || o.hc !== 10'd799 || o.vc !== 10'd524) begin
            bad++; $display("FAIL midreset_def got hc=%0d vc=%0d hs=%b vs=%b want 799 524 1 1", o.hc, o.vc, o.hsync, o.vsync);
        end
        cyc_def(1'b1, e, o);
        cyc_def(1'b1, e, o);
        total++;
        if (o.hc !== 10'd0 || o.vc !== 10'd0 || o.fs !== 1'b1) begin
            bad++; $display("FAIL restart_def got hc=%0d vc=%0d fs=%b want 0 0 1", o.hc, o.vc, o.fs);
        end

        cyc_mid(1'b0, e, o);
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            cyc_mid(1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL pre_reset_mid got=%h want=%h", o, e); end
            if (!o.hsync && !o.vsync) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL reach_syncs got found=0 want 1"); end
        cyc_mid(1'b0, e, o);
        total++;
        if (o.hsync !== 1'b1 || o.vsync !== 1'b1 || o.hc !== 10'd31 || o.vc !== 10'd18) begin
            bad++; $display("FAIL midreset_mid got hc=%0d vc=%0d hs=%b vs=%b want 31 18 1 1", o.hc, o.vc, o.hsync, o.vsync);
        end
        for (int i = 0; i < 3; i++) cyc_mid(1'b1, e, o);
        total++;
        if (o.hc !== 10'd0 || o.vc !== 10'd0 || o.fs !== 1'b1 || o.vidon !== 1'b1) begin
            bad++; $display("FAIL restart_mid got hc=%0d vc=%0d fs=%b want 0 0 1", o.hc, o.vc, o.fs);
        end
    endtask

    task automatic test_small_raster();
        exp_t e, o, prev;
        int last_ls = -1, last_fs = -1, fs_cnt = 0, ce_zero = 0;
        logic [15:0] hmask = '0;
        logic [15:0] vmask = '0;
        cyc_sml(1'b0, e, prev);
        cyc_sml(1'b0, e, prev);
        for (int cyc = 1; cyc <= 256; cyc++) begin
            cyc_sml(1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL small_scan cyc=%0d got=%h want=%h", cyc, o, e); end
            if (!o.pix_ce) ce_zero++;
            if (!o.hsync) hmask = hmask | (16'd1 << o.hc);
            if (!o.vsync) vmask = vmask | (16'd1 << o.vc);
            if (o.ls && !prev.ls) begin
                if (last_ls >= 0) begin
                    total++;
                    if (cyc - last_ls != 12) begin bad++; $display("FAIL line_period got=%0d want=12", cyc - last_ls); end
                end
                last_ls = cyc;
            end
            if (o.fs && !prev.fs) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    total++;
                    if (cyc - last_fs != 84) begin bad++; $display("FAIL frame_period got=%0d want=84", cyc - last_fs); end
                end
                last_fs = cyc;
            end
            prev = o;
        end
        total++;
        if (ce_zero != 0) begin bad++; $display("FAIL pix_ce_const got zeros=%0d want 0", ce_zero); end
        total++;
        if (hmask !== 16'h0600) begin bad++; $display("FAIL small_hsync_pos got=%h want=0600", hmask); end
        total++;
        if (vmask !== 16'h0020) begin bad++; $display("FAIL small_vsync_pos got=%h want=0020", vmask); end
        total++;
        if (fs_cnt != 4) begin bad++; $display("FAIL small_frames got=%0d want=4", fs_cnt); end
    endtask

    task automatic test_frame_scan();
        exp_t e, o, prev;
        int vid_bad = 0, fs_cnt = 0, last_fs = -1, fs_run = 0;
        logic [31:0] vmask = '0;
        cyc_mid(1'b0, e, prev);
        for (int cyc = 1; cyc <= 3 * 1824 + 6; cyc++) begin
            cyc_mid(1'b1, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL frame_scan cyc=%0d got=%h want=%h", cyc, o, e); end
            if (o.vc >= 10'd12 && o.vidon) vid_bad++;
            if (!o.vsync) vmask = vmask | (32'd1 << o.vc);
            if (o.vsync !== prev.vsync) begin
                total++;
                if (o.hc !== 10'd0 || prev.hc === 10'd0) begin
                    bad++; $display("FAIL vsync_edge_align got hc %0d->%0d want ->0", prev.hc, o.hc);
                end
            end
            if (o.fs && !prev.fs) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    total++;
                    if (cyc - last_fs != 1824) begin bad++; $display("FAIL mid_frame_period got=%0d want=1824", cyc - last_fs); end
                end
                last_fs = cyc;
            end
            if (o.fs) begin
                fs_run++;
            end else if (fs_run != 0) begin
                total++;
                if (fs_run != 3) begin bad++; $display("FAIL frame_start_width got=%0d want=3", fs_run); end
                fs_run = 0;
            end
            prev = o;
        end
        total++;
        if (vid_bad != 0) begin bad++; $display("FAIL vidon_blank got=%0d want 0", vid_bad); end
        total++;
        if (vmask !== 32'h0001_C000) begin bad++; $display("FAIL mid_vsync_lines got=%h want=0001c000", vmask); end
        total++;
        if (fs_cnt != 4) begin bad++; $display("FAIL mid_frames got=%0d want=4", fs_cnt); end
    endtask

    task automatic test_random();
        exp_t e, o;
        logic r;
        cyc_mid(1'b0, e, o);
        for (int cyc = 0; cyc < 3 * 1824; cyc++) begin
            r = ($urandom_range(0, 1499) != 0);
            cyc_mid(r, e, o);
            total++;
            if (o !== e) begin bad++; $display("FAIL random_run cyc=%0d rst=%b got=%h want=%h", cyc, r, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_line_scan();
        test_mid_reset();
        test_small_raster();
        test_frame_scan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
